// File: rtl/ahb_to_fpga_sram.sv
// AHB-Lite slave front end for the block-RAM SRAM: zero-wait reads and writes, one-entry write buffer with read merge.
// Optional alignment checking with a two-cycle ERROR response is compiled in by defining AHB_SRAM_ALIGN_CHECK_EN.
//
// error FSM (AHB_SRAM_ALIGN_CHECK_EN only)
//   state    | meaning
//   ERR_IDLE | normal operation, OKAY response
//   ERR1     | first ERROR cycle, HREADYOUT low, no transfer accepted
//   ERR2     | second ERROR cycle, HREADYOUT high
module ahb_to_fpga_sram #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS
);

  logic          ap_raw;
  logic          ap_ok;
  logic          rd_ap;
  logic          wr_ap;
  logic [AW-1:0] ap_addr;
  logic [3:0]    ap_mask;
  logic          match;
  logic          drain;

  logic          rd_dph;
  logic          merge_q;
  logic          wr_dph;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_mask;
  logic          buf_pend;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;

  logic unused_haddr;
  assign unused_haddr = ^HADDR[31:AW+2];

  assign ap_raw  = HSEL & HREADY & HTRANS[1] & ~HRESET;
  assign ap_addr = HADDR[AW+1:2];

  always_comb begin
    ap_mask = 4'b1111;
    case (HSIZE)
      3'd0:    ap_mask = 4'b0001 << HADDR[1:0];
      3'd1:    ap_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ALIGN_CHECK_EN
  typedef enum logic [1:0] {ERR_IDLE, ERR1, ERR2} err_state_t;
  err_state_t err_state, err_next;
  logic       misaligned;
  logic       err_start;

  always_comb begin
    misaligned = 1'b0;
    case (HSIZE)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = HADDR[0];
      3'd2:    misaligned = |HADDR[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign ap_ok     = ap_raw & ~misaligned & (err_state != ERR1);
  assign err_start = ap_raw & misaligned & (err_state != ERR1);

  always_ff @(posedge HCLK) begin
    if (HRESET) err_state <= ERR_IDLE;
    else        err_state <= err_next;
  end

  always_comb begin
    err_next = err_state;
    case (err_state)
      ERR_IDLE: if (err_start) err_next = ERR1;
      ERR1:     err_next = ERR2;
      ERR2:     err_next = err_start ? ERR1 : ERR_IDLE;
      default:  err_next = ERR_IDLE;
    endcase
  end

  assign HREADYOUT = (err_state != ERR1);
  assign HRESP     = (err_state != ERR_IDLE);
`else
  assign ap_ok     = ap_raw;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  assign rd_ap = ap_ok & ~HWRITE;
  assign wr_ap = ap_ok & HWRITE;
  assign match = (buf_pend & (buf_addr == ap_addr)) | (wr_dph & (wr_addr == ap_addr));
  assign drain = buf_pend & ~rd_ap & ~wr_dph;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_dph   <= 1'b0;
      merge_q  <= 1'b0;
      wr_dph   <= 1'b0;
      wr_addr  <= '0;
      wr_mask  <= 4'b0000;
      buf_pend <= 1'b0;
      buf_addr <= '0;
      buf_mask <= 4'b0000;
      buf_data <= 32'h0;
    end else begin
      rd_dph  <= rd_ap;
      merge_q <= rd_ap & match;
      wr_dph  <= wr_ap;
      if (wr_ap) begin
        wr_addr <= ap_addr;
        wr_mask <= ap_mask;
      end
      // A write data phase colliding with a read address phase parks in the buffer.
      if (wr_dph & rd_ap) begin
        buf_addr <= wr_addr;
        buf_mask <= wr_mask;
        buf_data <= HWDATA;
        buf_pend <= 1'b1;
      end else if (drain) begin
        buf_pend <= 1'b0;
      end
    end
  end

  // Port priority: read address phase, then write-through, then buffer drain.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMADDR  = '0;
    SRAMWEN   = 4'b0000;
    SRAMWDATA = 32'h0;
    if (rd_ap) begin
      SRAMCS   = 1'b1;
      SRAMADDR = ap_addr;
    end else if (wr_dph) begin
      SRAMCS    = 1'b1;
      SRAMADDR  = wr_addr;
      SRAMWEN   = wr_mask;
      SRAMWDATA = HWDATA;
    end else if (drain) begin
      SRAMCS    = 1'b1;
      SRAMADDR  = buf_addr;
      SRAMWEN   = buf_mask;
      SRAMWDATA = buf_data;
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (rd_dph) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (merge_q & buf_mask[i]) ? buf_data[8*i +: 8] : SRAMRDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_to_fpga_sram.sv
// Bench for ahb_to_fpga_sram: behavioural SRAM, shadow memory model and a read-data scoreboard queue.
module tb_ahb_to_fpga_sram;
  localparam int AW = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWEN;
  logic          SRAMCS;

  ahb_to_fpga_sram #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
  );

  always #5 HCLK = ~HCLK;

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  logic [31:0] exp_q  [$];

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR[7:0]];
      else begin
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR[7:0]][8*b +: 8] <= SRAMWDATA[8*b +: 8];
      end
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        rd_dph_tb = 1'b0;
  logic        model_err = 1'b0;
  logic [31:0] nxt_wdata = 32'h0;
  logic        obs_cs, obs_ready, obs_resp;
  logic [3:0]  obs_wen;
  logic [AW-1:0] obs_addr;

  function automatic logic [3:0] tb_mask(input logic [1:0] a, input logic [2:0] s);
    if (s == 3'd0) return 4'b0001 << a;
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // kind: 0 idle, 1 read, 2 write. One bus cycle; HWDATA carries the previous write's data.
  task automatic op(input int kind, input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] data);
    logic [3:0]  m;
    logic [31:0] exp_v;
    HWDATA = nxt_wdata;
    HSEL   = (kind != 0);
    HTRANS = (kind != 0) ? 2'b10 : 2'b00;
    HWRITE = (kind == 2);
    HADDR  = addr;
    HSIZE  = size;
    nxt_wdata = (kind == 2) ? data : 32'h0;
    if (kind == 2 && !model_err) begin
      m = tb_mask(addr[1:0], size);
      for (int b = 0; b < 4; b++)
        if (m[b]) shadow[addr[9:2]][8*b +: 8] = data[8*b +: 8];
    end
    if (kind == 1) exp_q.push_back(shadow[addr[9:2]]);
    @(negedge HCLK);
    if (rd_dph_tb) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL hrdata: read data phase with empty scoreboard, got %h", HRDATA);
      end else begin
        exp_v = exp_q.pop_front();
        if (HRDATA !== exp_v) begin
          n_fail++;
          $display("FAIL hrdata: got %h expected %h", HRDATA, exp_v);
        end
      end
    end
    obs_cs    = SRAMCS;
    obs_wen   = SRAMWEN;
    obs_addr  = SRAMADDR;
    obs_ready = HREADYOUT;
    obs_resp  = HRESP;
    rd_dph_tb = (kind == 1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
    HSIZE = 3'd0; HWDATA = 32'h0; HREADY = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    n_checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || SRAMCS !== 1'b0 || SRAMWEN !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_held: rdy=%b resp=%b rdata=%h cs=%b wen=%b expected 1 0 0 0 0",
               HREADYOUT, HRESP, HRDATA, SRAMCS, SRAMWEN);
    end
    HRESET = 1'b0;
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b expected 1", obs_ready); end
    n_checks++;
    if (obs_resp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b expected 0", obs_resp); end
    n_checks++;
    if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA); end
    n_checks++;
    if (obs_cs !== 1'b0 || obs_wen !== 4'b0) begin
      n_fail++; $display("FAIL reset_sram: cs=%b wen=%b expected 0 0", obs_cs, obs_wen);
    end
  endtask

  task automatic test_word_write_read();
    op(2, 32'h10, 3'd2, 32'hDEADBEEF);
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_wen !== 4'hF || obs_addr !== 16'd4) begin
      n_fail++; $display("FAIL word_wr_sram: wen=%h addr=%h expected F 0004", obs_wen, obs_addr);
    end
    op(1, 32'h10, 3'd2, 32'h0);
    n_checks++;
    if (obs_cs !== 1'b1 || obs_wen !== 4'h0) begin
      n_fail++; $display("FAIL word_rd_cs: cs=%b wen=%h expected 1 0", obs_cs, obs_wen);
    end
    op(0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic test_merge();
    op(2, 32'h10, 3'd2, 32'h11223344);
    op(0, 32'h0, 3'd0, 32'h0);
    op(2, 32'h13, 3'd0, 32'hAA000000);
    op(1, 32'h10, 3'd2, 32'h0);
    n_checks++;
    if (obs_cs !== 1'b1 || obs_wen !== 4'b0000) begin
      n_fail++; $display("FAIL merge_read_owns: cs=%b wen=%b expected 1 0000", obs_cs, obs_wen);
    end
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_wen !== 4'b1000 || obs_addr !== 16'd4) begin
      n_fail++; $display("FAIL merge_drain: wen=%b addr=%h expected 1000 0004", obs_wen, obs_addr);
    end
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (mem[4] !== 32'hAA223344) begin
      n_fail++; $display("FAIL merge_sram_content: got %h expected aa223344", mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    int ready_bad;
    op(2, 32'h48, 3'd2, 32'hCAFEF00D);
    op(0, 32'h0, 3'd0, 32'h0);
    ready_bad = 0;
    op(2, 32'h40, 3'd2, 32'h01010101); if (obs_ready !== 1'b1) ready_bad++;
    op(1, 32'h40, 3'd2, 32'h0);        if (obs_ready !== 1'b1) ready_bad++;
    op(2, 32'h44, 3'd2, 32'h02020202); if (obs_ready !== 1'b1) ready_bad++;
    op(1, 32'h48, 3'd2, 32'h0);        if (obs_ready !== 1'b1) ready_bad++;
    op(2, 32'h48, 3'd2, 32'h03030303); if (obs_ready !== 1'b1) ready_bad++;
    op(1, 32'h44, 3'd2, 32'h0);        if (obs_ready !== 1'b1) ready_bad++;
    op(2, 32'h4C, 3'd2, 32'h04040404); if (obs_ready !== 1'b1) ready_bad++;
    op(1, 32'h4C, 3'd2, 32'h0);        if (obs_ready !== 1'b1) ready_bad++;
    op(0, 32'h0, 3'd0, 32'h0);         if (obs_ready !== 1'b1) ready_bad++;
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (ready_bad != 0) begin
      n_fail++; $display("FAIL b2b_hreadyout: %0d low cycles expected 0", ready_bad);
    end
    op(1, 32'h48, 3'd2, 32'h0);
    op(1, 32'h40, 3'd2, 32'h0);
    op(0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic test_halfword();
    op(2, 32'h20, 3'd2, 32'h01020304);
    op(0, 32'h0, 3'd0, 32'h0);
    op(2, 32'h22, 3'd1, 32'h55660000);
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_wen !== 4'b1100) begin
      n_fail++; $display("FAIL half_wen: got %b expected 1100", obs_wen);
    end
    op(1, 32'h20, 3'd2, 32'h0);
    op(0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic test_misaligned();
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    model_err = 1'b1;
    op(2, 32'h02, 3'd2, 32'h99887766);
    model_err = 1'b0;
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_ready !== 1'b0 || obs_resp !== 1'b1 || obs_wen !== 4'b0) begin
      n_fail++; $display("FAIL err1: rdy=%b resp=%b wen=%b expected 0 1 0000", obs_ready, obs_resp, obs_wen);
    end
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_ready !== 1'b1 || obs_resp !== 1'b1 || obs_wen !== 4'b0) begin
      n_fail++; $display("FAIL err2: rdy=%b resp=%b wen=%b expected 1 1 0000", obs_ready, obs_resp, obs_wen);
    end
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_ready !== 1'b1 || obs_resp !== 1'b0) begin
      n_fail++; $display("FAIL err_exit: rdy=%b resp=%b expected 1 0", obs_ready, obs_resp);
    end
`else
    op(2, 32'h02, 3'd2, 32'h99887766);
    op(0, 32'h0, 3'd0, 32'h0);
    n_checks++;
    if (obs_wen !== 4'hF || obs_addr !== 16'd0 || obs_resp !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_wr: wen=%h addr=%h resp=%b expected F 0000 0", obs_wen, obs_addr, obs_resp);
    end
    op(1, 32'h00, 3'd2, 32'h0);
    op(0, 32'h0, 3'd0, 32'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_merge();
    test_back_to_back();
    test_halfword();
    test_misaligned();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drained: %0d reads outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_to_fpga_sram.md
# ahb_to_fpga_sram

AHB-Lite slave that fronts the on-chip block-RAM SRAM and converts bus transfers into its single-port CS/WREN/ADDR/WDATA protocol with pipelined read return. Sustains zero-wait-state reads and writes. Writes go through a one-entry write buffer when a write data phase collides with a read address phase. Read data is merged with any pending buffered bytes. Sits between the bus matrix slave port and the SRAM macro.

## Interface
- AW, 16, SRAM word-address width; decoded byte address is HADDR[AW+1:0]
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  32  byte address; bits [AW+1:0] used
- HTRANS  in  2  transfer type; HTRANS[1]=1 marks NONSEQ/SEQ
- HSIZE  in  3  0=byte, 1=halfword, 2=word
- HWRITE  in  1  1=write
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- SRAMRDATA  in  32  SRAM read data, valid the cycle after a read CS
- SRAMADDR  out  AW  SRAM word address
- SRAMWDATA  out  32  SRAM write data
- SRAMWEN  out  4  byte write enables
- SRAMCS  out  1  SRAM chip select

## Operation
- Accepted transfer (AP): HSEL & HREADY & HTRANS[1]. rd_ap = AP & ~HWRITE; wr_ap = AP & HWRITE.
- Byte mask: HSIZE=0 -> 4'b0001<<HADDR[1:0]; HSIZE=1 -> HADDR[1] ? 4'b1100 : 4'b0011; HSIZE>=2 -> 4'b1111.
- rd_ap: SRAMCS=1, SRAMADDR=HADDR[AW+1:2], SRAMWEN=0, same cycle (combinational). rd_dph is set for the next cycle.
- wr_ap: HADDR[AW+1:2] and the mask are registered into wr_addr/wr_mask, and wr_dph is set.
- Write data phase (wr_dph=1), no rd_ap:
  - Write-through: SRAMCS=1, SRAMADDR=wr_addr, SRAMWEN=wr_mask, SRAMWDATA=HWDATA.
- Write data phase coinciding with rd_ap:
  - The read owns the SRAM port.
  - buf_addr/buf_mask/buf_data <= wr_addr/wr_mask/HWDATA; buf_pend <= 1.
- Drain: any cycle with buf_pend & ~rd_ap & ~wr_dph writes the buffer. SRAMWEN=buf_mask, SRAMWDATA=buf_data, and buf_pend clears.
  - Every wr_ap cycle has no rd_ap, so the buffer is always empty at any write data phase. No overflow case exists.
- Merge: at rd_ap, merge_q <= match, where match = (buf_pend & buf_addr==HADDR[AW+1:2]) | (wr_dph & wr_addr==HADDR[AW+1:2]).
  - In rd_dph, HRDATA byte i = (merge_q & buf_mask[i]) ? buf_data byte i : SRAMRDATA byte i.
  - buf_data is stable through rd_dph because reload only happens in write data phases.
- HRDATA = 0 outside rd_dph.
- SRAM priority per cycle: rd_ap > write-through > drain > idle (SRAMCS=0, SRAMWEN=0).
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS=0, SRAMWEN=0, SRAMADDR=0, SRAMWDATA=0. buf_pend, wr_dph, rd_dph, merge_q and error state all clear. A pending buffered write at reset is discarded.

## Timing
- Read: AP in cycle N, HRDATA valid in cycle N+1 with HREADYOUT=1 (zero wait).
- Write: AP in N, data in N+1. The SRAM write happens in N+1 (write-through) or in the first later cycle with no rd_ap and no wr_dph (buffered).
- Back-to-back read/write in any order: HREADYOUT stays 1, except for error responses.
- HSEL=0 or HTRANS IDLE/BUSY: no state change except drain; OKAY response.

## Configuration
- AHB_SRAM_ALIGN_CHECK_EN defined:
  - Misaligned transfers produce an ERROR: HSIZE=1 with HADDR[0]=1, HSIZE=2 with HADDR[1:0]!=0, or HSIZE>2.
  - These transfers cause no SRAM access and no buffer load.
  - FSM ERR_IDLE -> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> ERR_IDLE.
  - Transfers are not accepted in ERR1. Drain is still permitted in ERR1/ERR2.
- Not defined: the FSM is absent and HRESP is tied 0. Misaligned transfers use the byte-mask rules above (low bits ignored per HSIZE).

## Test plan
- Reset, then idle: HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS=0, SRAMWEN=0.
- Word write 0xDEADBEEF to 0x10, idle, read 0x10 -> SRAMWEN=4'hF in the data phase; HRDATA=0xDEADBEEF one cycle after the read AP.
- Byte write 0xAA to 0x13, then an immediate read of 0x10 in the write data phase; prior SRAM content 0x11223344 -> buf_pend=1, HRDATA=0xAA223344, drain on the next free cycle.
- Alternating W/R/W/R to 4 distinct addresses, no idle cycles -> HREADYOUT constantly 1; every read returns the last written value; the buffer never holds two entries.
- Halfword write 0x5566 to 0x22, read 0x20 -> SRAMWEN=4'b1100, HRDATA[31:16]=0x5566.
- With AHB_SRAM_ALIGN_CHECK_EN: word write to 0x02 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; SRAMWEN stays 0. Without the macro: SRAMWEN=4'hF at word 0.
